// File: rtl/uart_apb_bridge_pkg.sv
// Shared constants and frame FSM state type for the UART-to-APB debug bridge.
package uart_apb_bridge_pkg;

   localparam logic [7:0] OPC_WRITE = 8'h57;
   localparam logic [7:0] OPC_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;

   typedef enum logic [2:0] {
      IDLE,
      OPC,
      ADDR,
      DATA,
      SETUP,
      ACCESS,
      RESP,
      NAK
   } state_t;

endpackage

// File: rtl/uart_apb_bridge_if.sv
// APB bus between the bridge (initiator) and the fabric it drives.
interface uart_apb_bridge_if;

   logic [31:0] m_apb_addr;
   logic        m_apb_sel;
   logic        m_apb_ena;
   logic        m_apb_write;
   logic [31:0] m_apb_wdata;
   logic [3:0]  m_apb_pstb;
   logic [31:0] m_apb_rdata;
   logic        m_apb_rready;

   modport master (
      output m_apb_addr, m_apb_sel, m_apb_ena, m_apb_write, m_apb_wdata, m_apb_pstb,
      input  m_apb_rdata, m_apb_rready
   );

   modport slave (
      input  m_apb_addr, m_apb_sel, m_apb_ena, m_apb_write, m_apb_wdata, m_apb_pstb,
      output m_apb_rdata, m_apb_rready
   );

endinterface

// File: rtl/uart_apb_bridge_phy.sv
// 8N1 UART byte engine: synchronised receiver with start-bit glitch rejection
// and a transmitter that accepts the next byte during the last stop-bit cycle.
module uart_apb_bridge_phy #(
   parameter int unsigned CLK_DIV = 868
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rxd,
   output logic       txd,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_ferr,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data
);

   localparam int unsigned    CW        = $clog2(CLK_DIV);
   localparam logic [CW-1:0]  BIT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_DIV / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t     rx_state;
   logic          rx_meta, rx_sync, rx_prev;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_sr;

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_sr    <= '0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_meta  <= rxd;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         rx_valid <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_sync) begin
                  rx_state <= RX_START;
                  rx_cnt   <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt <= '0;
                  rx_sr  <= {rx_sync, rx_sr[7:1]};
                  rx_bit <= rx_bit + 1'b1;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_valid <= 1'b1;
                  rx_data  <= rx_sr;
                  rx_ferr  <= !rx_sync;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   logic          tx_busy;
   logic [8:0]    tx_sr;
   logic [3:0]    tx_bit;
   logic [CW-1:0] tx_cnt;

   // Ready in the final stop-bit cycle so response bytes go out back-to-back.
   assign tx_ready = !tx_busy || (tx_bit == 4'd9 && tx_cnt == BIT_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         txd     <= 1'b1;
         tx_busy <= 1'b0;
         tx_sr   <= '1;
         tx_bit  <= '0;
         tx_cnt  <= '0;
      end else if (tx_valid && tx_ready) begin
         txd     <= 1'b0;
         tx_busy <= 1'b1;
         tx_sr   <= {1'b1, tx_data};
         tx_bit  <= '0;
         tx_cnt  <= '0;
      end else if (tx_busy) begin
         if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
               tx_busy <= 1'b0;
            end else begin
               tx_bit <= tx_bit + 1'b1;
               txd    <= tx_sr[0];
               tx_sr  <= {1'b1, tx_sr[8:1]};
            end
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_apb_bridge.sv
// UART-driven APB initiator: decodes write/read frames, runs one APB transfer
// and returns ACK, read data or NAK. Optional UART_APB_BRIDGE_TIMEOUT_EN drops stalled frames.
module uart_apb_bridge
   import uart_apb_bridge_pkg::*;
#(
   parameter int unsigned CLK_DIV        = 868,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  uart_rxd,
   output logic                  uart_txd,
   output logic                  busy,
   uart_apb_bridge_if.master     apb
);

   state_t      state;
   logic [7:0]  opc;
   logic        is_write;
   logic [1:0]  byte_cnt;
   logic [31:0] addr_sr, data_sr, resp_sr;
   logic [1:0]  tx_left;
   logic        rx_valid, rx_ferr, tx_valid, tx_ready, timeout_hit;
   logic [7:0]  rx_data, tx_data;

   uart_apb_bridge_phy #(.CLK_DIV(CLK_DIV)) u_phy (
      .clock    (clock),
      .reset    (reset),
      .rxd      (uart_rxd),
      .txd      (uart_txd),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ferr  (rx_ferr),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_data  (tx_data)
   );

   // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
   always_comb begin
      tx_valid = 1'b0;
      tx_data  = resp_sr[31:24];
      if (state == ACCESS && apb.m_apb_rready) begin
         // First response byte leaves on the completion edge itself.
         tx_valid = 1'b1;
         tx_data  = is_write ? RSP_ACK : apb.m_apb_rdata[31:24];
      end else if ((state == RESP || state == NAK) && tx_left != 2'd0) begin
         tx_valid = 1'b1;
      end
   end

`ifdef UART_APB_BRIDGE_TIMEOUT_EN
   logic [31:0] to_cnt;
   logic        in_frame;

   assign in_frame    = state inside {OPC, ADDR, DATA};
   assign timeout_hit = in_frame && (to_cnt == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                      to_cnt <= '0;
      else if (rx_valid || !in_frame) to_cnt <= '0;
      else                            to_cnt <= to_cnt + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         opc             <= '0;
         is_write        <= 1'b0;
         byte_cnt        <= '0;
         addr_sr         <= '0;
         data_sr         <= '0;
         resp_sr         <= '0;
         tx_left         <= '0;
         busy            <= 1'b0;
         apb.m_apb_addr  <= '0;
         apb.m_apb_sel   <= 1'b0;
         apb.m_apb_ena   <= 1'b0;
         apb.m_apb_write <= 1'b0;
         apb.m_apb_wdata <= '0;
         apb.m_apb_pstb  <= '0;
      end else if (timeout_hit) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rx_valid && !rx_ferr) begin
                  opc   <= rx_data;
                  state <= OPC;
                  busy  <= 1'b1;
               end
            end
            OPC: begin
               byte_cnt <= '0;
               is_write <= (opc == OPC_WRITE);
               if (opc == OPC_WRITE || opc == OPC_READ) begin
                  state <= ADDR;
               end else begin
                  state   <= NAK;
                  resp_sr <= {RSP_NAK, 24'h0};
                  tx_left <= 2'd1;
               end
            end
            ADDR: begin
               if (rx_valid && rx_ferr) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (rx_valid) begin
                  addr_sr  <= {addr_sr[23:0], rx_data};
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_cnt == 2'd3 && is_write) begin
                     state <= DATA;
                  end else if (byte_cnt == 2'd3) begin
                     state           <= SETUP;
                     apb.m_apb_addr  <= {addr_sr[23:0], rx_data};
                     apb.m_apb_write <= 1'b0;
                     apb.m_apb_wdata <= '0;
                     apb.m_apb_pstb  <= 4'h0;
                     apb.m_apb_sel   <= 1'b1;
                     apb.m_apb_ena   <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (rx_valid && rx_ferr) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (rx_valid) begin
                  data_sr  <= {data_sr[23:0], rx_data};
                  byte_cnt <= byte_cnt + 1'b1;
                  if (byte_cnt == 2'd3) begin
                     state           <= SETUP;
                     apb.m_apb_addr  <= addr_sr;
                     apb.m_apb_write <= 1'b1;
                     apb.m_apb_wdata <= {data_sr[23:0], rx_data};
                     apb.m_apb_pstb  <= 4'hF;
                     apb.m_apb_sel   <= 1'b1;
                     apb.m_apb_ena   <= 1'b0;
                  end
               end
            end
            SETUP: begin
               apb.m_apb_ena <= 1'b1;
               state         <= ACCESS;
            end
            ACCESS: begin
               if (apb.m_apb_rready) begin
                  apb.m_apb_sel <= 1'b0;
                  apb.m_apb_ena <= 1'b0;
                  resp_sr       <= {apb.m_apb_rdata[23:0], 8'h00};
                  tx_left       <= is_write ? 2'd0 : 2'd3;
                  state         <= RESP;
               end
            end
            RESP, NAK: begin
               if (tx_valid && tx_ready) begin
                  resp_sr <= {resp_sr[23:0], 8'h00};
                  tx_left <= tx_left - 2'd1;
               end else if (tx_left == 2'd0 && tx_ready) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Bench for uart_apb_bridge at CLK_DIV = 16: host-side UART model, APB responder
// and frame-level expectations; timeout scenario runs when UART_APB_BRIDGE_TIMEOUT_EN is set.
module tb_uart_apb_bridge;

   localparam int DIV = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic uart_rxd = 1'b1;
   logic uart_txd;
   logic busy;

   uart_apb_bridge_if apb ();

   uart_apb_bridge #(.CLK_DIV(DIV), .TIMEOUT_CYCLES(2000)) dut (
      .clock    (clock),
      .reset    (reset),
      .uart_rxd (uart_rxd),
      .uart_txd (uart_txd),
      .busy     (busy),
      .apb      (apb)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end else begin
         n_pass++;
      end
   endtask

   // Expectations for the frame in flight, set from the frame bytes alone.
   logic        exp_apb_allowed = 1'b0;
   logic [31:0] exp_addr  = '0;
   logic [31:0] exp_wdata = '0;
   logic        exp_write = 1'b0;
   logic [3:0]  exp_pstb  = '0;
   int          exp_waits = 0;
   logic        hold_rready = 1'b0;

   // Observations gathered by the monitors.
   int          apb_done, setup_cnt, ena_cnt, done_cyc, busy_fall;
   logic [31:0] last_addr, last_wdata;
   logic        last_write;
   logic [3:0]  last_pstb;
   logic [7:0]  rx_q[$];
   int          rx_start[$];
   logic [7:0]  tx_q[$];

   // APB responder plus per-cycle comparison of the bus against expectations.
   initial begin
      int  acc;
      logic busy_prev;
      acc = 0;
      busy_prev = 1'b0;
      apb.m_apb_rready = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            apb.m_apb_rready = 1'b0;
            acc = 0;
            busy_prev = 1'b0;
         end else begin
            if (busy_prev && !busy) busy_fall = cyc;
            busy_prev = busy;
            if (!apb.m_apb_sel) begin
               if (apb.m_apb_ena) check("ena_without_sel", apb.m_apb_ena, 1'b0);
               apb.m_apb_rready = 1'b0;
               acc = 0;
            end else if (!exp_apb_allowed) begin
               check("unexpected_sel", apb.m_apb_sel, 1'b0);
            end else begin
               check("apb_addr", apb.m_apb_addr, exp_addr);
               check("apb_write", apb.m_apb_write, exp_write);
               check("apb_pstb", apb.m_apb_pstb, exp_pstb);
               if (exp_write) check("apb_wdata", apb.m_apb_wdata, exp_wdata);
               if (!apb.m_apb_ena) begin
                  setup_cnt++;
               end else begin
                  ena_cnt++;
                  apb.m_apb_rready = !hold_rready && (acc >= exp_waits);
                  acc++;
                  if (apb.m_apb_rready) begin
                     apb_done++;
                     done_cyc   = cyc;
                     last_addr  = apb.m_apb_addr;
                     last_wdata = apb.m_apb_wdata;
                     last_write = apb.m_apb_write;
                     last_pstb  = apb.m_apb_pstb;
                  end
               end
            end
         end
      end
   end

   // Host UART receiver: samples each bit mid-way, LSB first.
   initial begin
      int         st;
      logic [7:0] b;
      forever begin
         @(negedge uart_txd);
         @(negedge clock);
         st = cyc;
         repeat (DIV / 2 - 1) @(negedge clock);
         check("tx_start_bit", uart_txd, 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clock);
            b[i] = uart_txd;
         end
         repeat (DIV) @(negedge clock);
         check("tx_stop_bit", uart_txd, 1'b1);
         rx_q.push_back(b);
         rx_start.push_back(st);
      end
   end

   initial begin
      #(600_000 * 10);
      $display("FAIL watchdog: run exceeded cycle budget, got cycle %0d", cyc);
      $fatal(1);
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rxd = 1'b0;
      repeat (DIV) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (DIV) @(negedge clock);
      end
      uart_rxd = stop;
      repeat (DIV) @(negedge clock);
      uart_rxd = 1'b1;
   endtask

   task automatic send_frame();
      foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
   endtask

   task automatic clear_obs();
      rx_q.delete();
      rx_start.delete();
      apb_done  = 0;
      setup_cnt = 0;
      ena_cnt   = 0;
      done_cyc  = -1;
      busy_fall = -1;
   endtask

   // Derives the expected APB transfer and response from tx_q, sends it, then checks.
   task automatic do_frame(input int waits, input logic [31:0] rd);
      logic [7:0] resp[$];
      int         n_apb;
      logic       done;
      int         last;
      resp = {};
      exp_waits = waits;
      apb.m_apb_rdata = rd;
      if (tx_q.size() == 9 && tx_q[0] == 8'h57) begin
         exp_write = 1'b1;
         exp_addr  = {tx_q[1], tx_q[2], tx_q[3], tx_q[4]};
         exp_wdata = {tx_q[5], tx_q[6], tx_q[7], tx_q[8]};
         exp_pstb  = 4'hF;
         resp.push_back(8'h06);
         n_apb = 1;
      end else if (tx_q.size() == 5 && tx_q[0] == 8'h52) begin
         exp_write = 1'b0;
         exp_addr  = {tx_q[1], tx_q[2], tx_q[3], tx_q[4]};
         exp_pstb  = 4'h0;
         for (int i = 3; i >= 0; i--) resp.push_back(rd[8*i +: 8]);
         n_apb = 1;
      end else begin
         resp.push_back(8'h15);
         n_apb = 0;
      end
      exp_apb_allowed = (n_apb != 0);
      clear_obs();
      send_frame();
      done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clock);
         done = !busy && (rx_q.size() >= resp.size());
      end
      check("frame_done_in_time", done, 1'b1);
      check("resp_count", rx_q.size(), resp.size());
      check("apb_count", apb_done, n_apb);
      check("busy_after_frame", busy, 1'b0);
      if (rx_q.size() == resp.size() && resp.size() > 0) begin
         foreach (resp[i]) check($sformatf("resp_byte%0d", i), rx_q[i], resp[i]);
         for (int i = 1; i < rx_start.size(); i++)
            check("resp_byte_gap", rx_start[i] - rx_start[i-1], 10 * DIV);
         last = rx_start.size() - 1;
         check("busy_fall_after_stop", busy_fall, rx_start[last] + 10 * DIV);
         if (n_apb != 0) check("txd_start_latency", rx_start[0], done_cyc + 1);
      end
      if (n_apb != 0) begin
         check("setup_cycles", setup_cnt, 1);
         check("access_cycles", ena_cnt, waits + 1);
      end
      exp_apb_allowed = 1'b0;
      repeat (20) @(negedge clock);
   endtask

   initial begin
      apb.m_apb_rdata = '0;
      repeat (3) @(negedge clock);
      check("rst_txd", uart_txd, 1'b1);
      check("rst_sel", apb.m_apb_sel, 1'b0);
      check("rst_ena", apb.m_apb_ena, 1'b0);
      check("rst_write", apb.m_apb_write, 1'b0);
      check("rst_addr", apb.m_apb_addr, 32'h0);
      check("rst_wdata", apb.m_apb_wdata, 32'h0);
      check("rst_pstb", apb.m_apb_pstb, 4'h0);
      check("rst_busy", busy, 1'b0);
      #2 reset = 1'b0;
      repeat (5) @(negedge clock);

      // Write with immediate ready.
      tx_q = {8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      do_frame(0, 32'h0);
      check("wr_addr_lit", last_addr, 32'h0001_0000);
      check("wr_wdata_lit", last_wdata, 32'hDEAD_BEEF);
      check("wr_write_lit", last_write, 1'b1);
      check("wr_pstb_lit", last_pstb, 4'hF);
      if (rx_q.size() > 0) check("wr_ack_lit", rx_q[0], 8'h06);

      // Read with three wait states.
      tx_q = {8'h52, 8'h00, 8'h02, 8'h00, 8'h04};
      do_frame(3, 32'h1234_5678);
      check("rd_addr_lit", last_addr, 32'h0002_0004);
      check("rd_pstb_lit", last_pstb, 4'h0);
      check("rd_ena_cycles_lit", ena_cnt, 4);
      if (rx_q.size() == 4) begin
         check("rd_b0_lit", rx_q[0], 8'h12);
         check("rd_b1_lit", rx_q[1], 8'h34);
         check("rd_b2_lit", rx_q[2], 8'h56);
         check("rd_b3_lit", rx_q[3], 8'h78);
      end

      // Unknown opcode.
      tx_q = {8'h41};
      do_frame(0, 32'h0);
      if (rx_q.size() > 0) check("nak_lit", rx_q[0], 8'h15);

`ifdef UART_APB_BRIDGE_TIMEOUT_EN
      // Stalled partial frame is dropped after the idle limit.
      clear_obs();
      exp_apb_allowed = 1'b0;
      tx_q = {8'h57, 8'h00, 8'h01};
      send_frame();
      check("to_busy_partial", busy, 1'b1);
      repeat (2500) @(negedge clock);
      check("to_busy_cleared", busy, 1'b0);
      check("to_no_resp", rx_q.size(), 0);
      check("to_no_apb", apb_done, 0);
      tx_q = {8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
      do_frame(0, 32'h0BAD_F00D);
`endif

      // Framing error on the second byte abandons the frame.
      clear_obs();
      exp_apb_allowed = 1'b0;
      send_byte(8'h52, 1'b1);
      send_byte(8'h00, 1'b0);
      repeat (400) @(negedge clock);
      check("ferr_busy", busy, 1'b0);
      check("ferr_no_resp", rx_q.size(), 0);
      check("ferr_no_apb", apb_done, 0);
      tx_q = {8'h52, 8'hAB, 8'hCD, 8'h00, 8'h10};
      do_frame(1, 32'hCAFE_F00D);
      check("ferr_next_addr_lit", last_addr, 32'hABCD_0010);

      // Reset while a read is stuck in ACCESS.
      clear_obs();
      hold_rready     = 1'b1;
      exp_apb_allowed = 1'b1;
      exp_write       = 1'b0;
      exp_addr        = 32'h0000_0100;
      exp_pstb        = 4'h0;
      tx_q = {8'h52, 8'h00, 8'h00, 8'h01, 8'h00};
      send_frame();
      for (int i = 0; i < 50 && !apb.m_apb_ena; i++) @(negedge clock);
      check("rst_test_in_access", apb.m_apb_ena, 1'b1);
      repeat (3) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("midrst_sel", apb.m_apb_sel, 1'b0);
      check("midrst_ena", apb.m_apb_ena, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_txd", uart_txd, 1'b1);
      check("midrst_addr", apb.m_apb_addr, 32'h0);
      exp_apb_allowed = 1'b0;
      hold_rready     = 1'b0;
      repeat (3) @(negedge clock);
      #2 reset = 1'b0;
      repeat (10) @(negedge clock);
      tx_q = {8'h57, 8'h10, 8'h00, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04};
      do_frame(0, 32'h0);
      check("post_rst_wdata_lit", last_wdata, 32'h0102_0304);
      if (rx_q.size() > 0) check("post_rst_ack_lit", rx_q[0], 8'h06);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_apb_bridge.md
# uart_apb_bridge

Debug bridge that receives command frames on a UART line and acts as an APB initiator: it decodes each frame, performs one 32-bit APB read or write, and returns a response over UART. It is the initiator end of the APB fabric, opposite the existing APB responders (RAM, ROM, UARTs, SPI, PLIC, GPIO, PWM). It drives a spare crossbar slave port, or an external mux in front of the pipeline's dmem port, to load and inspect memory without the CPU.

## Interface
- CLK_DIV, 868: clock cycles per UART bit (8N1); minimum 8.
- TIMEOUT_CYCLES, 1000000: maximum idle gap between bytes inside one frame.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- uart_rxd  in  1  host to bridge serial line; idles high.
- uart_txd  out  1  bridge to host serial line; idles high.
- m_apb_addr  out  32  APB address.
- m_apb_sel  out  1  APB select.
- m_apb_ena  out  1  APB enable.
- m_apb_write  out  1  1 = write.
- m_apb_wdata  out  32  write data.
- m_apb_pstb  out  4  byte strobes.
- m_apb_rdata  in  32  read data.
- m_apb_rready  in  1  responder ready; may be tied to 1.
- busy  out  1  high from first opcode byte until last response stop bit; drives the external mux select.

## Operation
- Frames, multi-byte fields MSB first:
  - Write: 0x57, addr[4], data[4]. Response: 0x06.
  - Read: 0x52, addr[4]. Response: data[4].
  - Any other first byte: response 0x15 (NAK). No APB activity.
- RX:
  - uart_rxd passes through a 2-flop synchronizer.
  - A falling edge in IDLE starts the bit counter. Start bit is re-sampled at CLK_DIV/2; if it reads high, the edge was a glitch and RX returns to idle.
  - Data bits are sampled every CLK_DIV cycles, LSB first, then the stop bit.
  - Stop bit = 0 is a framing error: the byte is dropped and any partial frame is abandoned (state returns to IDLE, no response).
- TX: start bit, 8 data bits LSB first, stop bit; each bit lasts CLK_DIV cycles. Response bytes go back-to-back with no idle gap.
- Top FSM states: IDLE, OPC, ADDR (4 bytes), DATA (4 bytes, write only), SETUP, ACCESS, RESP, NAK.
  - IDLE → OPC on the first byte.
  - A valid opcode goes to ADDR; an invalid one goes to NAK.
  - ADDR → DATA for a write; ADDR → SETUP for a read.
  - DATA → SETUP after the 4th data byte.
  - SETUP → ACCESS after exactly 1 cycle.
  - ACCESS → RESP on the cycle where m_apb_rready = 1.
  - RESP and NAK → IDLE after the last stop bit.
- APB transfer:
  - SETUP: sel = 1, ena = 0.
  - ACCESS: sel = 1, ena = 1, held until rready.
  - addr, write, wdata, pstb are stable from SETUP through the completion cycle.
  - pstb = 0xF for writes, 0x0 for reads.
  - Read data is captured on the completion cycle.
  - In the cycle after completion, sel = 0 and ena = 0.
  - There is no APB timeout; a responder that never asserts rready hangs the bridge until reset.
- Bytes that arrive during SETUP, ACCESS, RESP or NAK are silently dropped. The host must wait for the response before sending the next frame.
- The addr[1:0] bits are passed through unmodified.

## Timing
- Reset values:
  - uart_txd = 1.
  - sel, ena, write = 0.
  - addr, wdata = 0.
  - pstb = 0.
  - busy = 0.
  - FSM in IDLE; all counters 0.
- Last frame byte's stop-bit sample to SETUP: 1 cycle.
- Minimum APB transfer: 2 cycles (SETUP plus one ACCESS cycle).
- APB completion to TX start bit (uart_txd falling): 1 cycle.
- Response length: 10·CLK_DIV cycles for a write or NAK; 40·CLK_DIV cycles for a read.
- Reset asserted mid-operation forces all outputs to reset values immediately. The frame is lost and the host must resend.

## Configuration
- UART_APB_BRIDGE_TIMEOUT_EN defined:
  - A counter clears on every received byte.
  - In OPC, ADDR or DATA, reaching TIMEOUT_CYCLES returns the FSM to IDLE silently.
- Not defined: the counter and parameter are unused and a partial frame waits indefinitely.

## Structure
- Package uart_apb_bridge_pkg holds:
  - opcode constants OPC_WRITE = 0x57, OPC_READ = 0x52;
  - response constants RSP_ACK = 0x06, RSP_NAK = 0x15;
  - the FSM state enum.
- Sub-module uart_apb_bridge_phy:
  - contains the RX synchronizer and deserializer, and the TX serializer;
  - byte-level interface: rx_valid/rx_data/rx_ferr and tx_valid/tx_ready/tx_data;
  - parameterized by CLK_DIV.
- Top level holds the frame FSM, shift registers, APB master and timeout counter.

## Test plan
All scenarios use CLK_DIV = 16.
- Write: send 57 00 01 00 00 DE AD BE EF with rready = 1 → one SETUP cycle then one ACCESS cycle with addr 0x00010000, wdata 0xDEADBEEF, write = 1, pstb 0xF → host receives 06.
- Read with wait states: send 52 00 02 00 04 with rdata 0x12345678 and rready low for 3 ACCESS cycles → ena high for 4 cycles, pstb 0x0 → host receives 12 34 56 78 with no inter-byte gaps.
- Bad opcode: send 41 → host receives 15, sel stays 0, busy returns to 0 after the NAK stop bit.
- Timeout (macro on, TIMEOUT_CYCLES = 2000): send 57 00 01, then idle 2500 cycles → FSM returns to IDLE with no APB activity; a following 52 00 00 00 00 completes normally.
- Framing error: send 52 00 with the second byte's stop bit forced to 0 → frame abandoned and no response; the next valid read frame completes.
- Reset during ACCESS (rready held 0), then reset asserted → sel = 0, ena = 0, busy = 0, uart_txd = 1 in the same cycle. After release, a full write frame completes correctly.
